tlb_walk_arbiter: RTL
=====================

Name: tlb_walk_arbiter

Overview:
- Shares one page-table walker (PTW) between the iTLB and the dTLB.
- Arbitrates their misses, registers the walk request, and routes the returned PTE or page fault back to the requesting side as a fill pulse or a page-fault pulse.
- Cancels instruction walks on pc_redirect or intr, and sequences SFENCE.VMA flushes so they never overlap an in-flight walk.
- Sits beside the separate caches, on the priv/pipeline boundary.

Parameters:
- VA_W, 32, virtual address width.
- ASID_W, ASID_LENGTH, ASID field width.
- STARVE_LIMIT, 4, number of consecutive dTLB grants after which a waiting iTLB miss wins.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- itlb_miss  in  1  iTLB miss, level, held until fill or fault.
- itlb_vaddr  in  VA_W  fetch virtual address.
- dtlb_miss  in  1  dTLB miss, level.
- dtlb_vaddr  in  VA_W  data virtual address.
- ex_mem_ren  in  1  missing data access is a load.
- ex_mem_wen  in  1  missing data access is a store.
- pc_redirect  in  1  fetch redirect; kills any instruction walk.
- intr  in  1  trap taken; kills any walk.
- fence_req  in  1  SFENCE.VMA request, level, held until fence_ack.
- fence_va  in  VA_W  fence address.
- fence_asid  in  ASID_W  fence ASID.
- ptw_req  out  1  walk request.
- ptw_vaddr  out  VA_W  walk address.
- ptw_is_store  out  1  walk is for a store (sets A/D checks).
- ptw_is_fetch  out  1  walk is for an instruction fetch.
- ptw_done  in  1  walk complete, 1-cycle pulse.
- ptw_fault  in  1  walk fault, valid with ptw_done.
- ptw_pte  in  32  leaf PTE, valid with ptw_done.
- itlb_fill  out  1  write fill_pte into the iTLB.
- dtlb_fill  out  1  write fill_pte into the dTLB.
- fill_pte  out  32  registered PTE.
- fetch_fault_insn_page  out  1  instruction page fault pulse.
- mem_fault_load_page  out  1  load page fault pulse.
- mem_fault_store_page  out  1  store page fault pulse.
- tlb_flush  out  1  flush pulse to both TLBs.
- flush_va  out  VA_W  address qualifier for tlb_flush.
- flush_asid  out  ASID_W  ASID qualifier for tlb_flush.
- fence_ack  out  1  fence complete, 1-cycle pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, starve_cnt 0.
- States: IDLE, WALK_I, WALK_D, DRAIN, FLUSH.
- IDLE priority, highest first: fence_req, then dtlb_miss (&& !intr), then itlb_miss (&& !pc_redirect && !intr).
  - fence_req wins -> FLUSH.
  - When both misses are pending and starve_cnt==STARVE_LIMIT, the iTLB wins instead.
  - Registered grant: miss seen in cycle n -> ptw_req=1 with ptw_vaddr/ptw_is_store/ptw_is_fetch in cycle n+1.
  - ptw_is_store = ex_mem_wen (store dominates when ren and wen are both set).
- starve_cnt:
  - +1 on each dTLB grant while itlb_miss is high, saturating at STARVE_LIMIT.
  - Cleared on an iTLB grant or when itlb_miss is low.
- WALK_x:
  - ptw_req and address held stable until ptw_done.
  - Without cancel or fence, ptw_done -> one registered response pulse in the next cycle, then IDLE:
    - !fault: fill to the granted side.
    - fault: fetch_fault_insn_page, or mem_fault_store_page if is_store, else mem_fault_load_page.
  - ptw_req drops the cycle after ptw_done.
- Cancel: intr in WALK_I/WALK_D, or pc_redirect in WALK_I (only if ptw_done is not in that same cycle), -> DRAIN.
  - ptw_req stays high until ptw_done; the result is discarded (no fill, no fault); then IDLE.
  - pc_redirect in WALK_D is ignored.
- ptw_done coincident with cancel: result discarded, next state IDLE.
- Fence mid-walk: fence_req in WALK_x -> the walk completes but its result is discarded, then FLUSH.
- FLUSH (1 cycle):
  - tlb_flush=1, fence_ack=1, flush_va/flush_asid = fence_va/fence_asid sampled on entry.
  - Next state IDLE; no grant is made in the FLUSH cycle.
- At most one response pulse per walk; responses never overlap tlb_flush.
- ptw_done in IDLE or FLUSH is ignored; flag it with a simulation assertion.
- nRST low mid-walk: immediate return to reset values. The walker shares the same reset, so no stale ptw_done is expected.

Decomposition:
- Add the walk_arb_state_t enum and the walk_src_t {SRC_I, SRC_D} typedef to priv_isa_types_pkg.
- ASID_LENGTH comes from the existing package.
- One natural sub-module: walk_starve_counter (saturating counter with clear), roughly 30 lines.
- Total RTL about 200 lines.

Test Plan:
- Lone dTLB load miss, vaddr 0x8000_1000; ptw_done 5 cycles later, pte 0x2000_00CF -> ptw_req/ptw_is_store=0 one cycle after the miss; dtlb_fill=1 with fill_pte=0x2000_00CF one cycle after ptw_done; no fault pulses.
- itlb_miss and dtlb_miss held continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I; ptw_is_fetch=1 only on the 5th walk.
- iTLB walk in flight, pc_redirect pulse at walk cycle 2 -> DRAIN; ptw_req held until ptw_done; itlb_fill and fetch_fault_insn_page stay 0.
- dTLB store walk returns ptw_fault=1 -> mem_fault_store_page pulses exactly 1 cycle; mem_fault_load_page=0.
- fence_req (va 0x4000_0000, asid 3) during WALK_D -> walk finishes with no dtlb_fill; next cycle tlb_flush=fence_ack=1 with flush_va=0x4000_0000, flush_asid=3.
- nRST asserted mid-WALK_I -> ptw_req and all pulses go 0 asynchronously; after release, the arbiter is in IDLE and accepts a new miss.

Source files
------------

// File: rtl/tlb_walk_arbiter_pkg.sv
// Shared types for the iTLB/dTLB page-table-walker arbiter.
package tlb_walk_arbiter_pkg;

   localparam int ASID_LENGTH = 9;

   typedef enum logic [2:0] {
      IDLE,
      WALK_I,
      WALK_D,
      DRAIN,
      FLUSH
   } walk_arb_state_t;

   typedef enum logic {
      SRC_I,
      SRC_D
   } walk_src_t;

endpackage

// File: rtl/tlb_walk_arbiter_if.sv
// Request/response channel between the walk arbiter and the page-table walker.
interface tlb_walk_arbiter_if #(
   parameter int VA_W = 32
);
   logic            ptw_req;
   logic [VA_W-1:0] ptw_vaddr;
   logic            ptw_is_store;
   logic            ptw_is_fetch;
   logic            ptw_done;
   logic            ptw_fault;
   logic [31:0]     ptw_pte;

   modport master (
      output ptw_req, ptw_vaddr, ptw_is_store, ptw_is_fetch,
      input  ptw_done, ptw_fault, ptw_pte
   );

   modport slave (
      input  ptw_req, ptw_vaddr, ptw_is_store, ptw_is_fetch,
      output ptw_done, ptw_fault, ptw_pte
   );
endinterface

// File: rtl/tlb_walk_arbiter_starve.sv
// Saturating count of back-to-back dTLB grants taken while an iTLB miss waits.
module walk_starve_counter #(
   parameter int LIMIT = 4
) (
   input  logic CLK,
   input  logic nRST,
   input  logic inc,
   input  logic clr,
   output logic sat
);
   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_reg, cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clr)
         cnt_next = '0;
      else if (inc && cnt_reg != CNT_W'(LIMIT))
         cnt_next = cnt_reg + 1'b1;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_next;
   end

   assign sat = (cnt_reg == CNT_W'(LIMIT));
endmodule

// File: rtl/tlb_walk_arbiter.sv
// Shares one page-table walker between the iTLB and dTLB, routes fills/faults
// back to the requester, and serialises SFENCE.VMA flushes against walks.
module tlb_walk_arbiter
   import tlb_walk_arbiter_pkg::*;
#(
   parameter int VA_W         = 32,
   parameter int ASID_W       = ASID_LENGTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              itlb_miss,
   input  logic [VA_W-1:0]   itlb_vaddr,
   input  logic              dtlb_miss,
   input  logic [VA_W-1:0]   dtlb_vaddr,
   input  logic              ex_mem_ren,
   input  logic              ex_mem_wen,
   input  logic              pc_redirect,
   input  logic              intr,
   input  logic              fence_req,
   input  logic [VA_W-1:0]   fence_va,
   input  logic [ASID_W-1:0] fence_asid,
   tlb_walk_arbiter_if.master ptw,
   output logic              itlb_fill,
   output logic              dtlb_fill,
   output logic [31:0]       fill_pte,
   output logic              fetch_fault_insn_page,
   output logic              mem_fault_load_page,
   output logic              mem_fault_store_page,
   output logic              tlb_flush,
   output logic [VA_W-1:0]   flush_va,
   output logic [ASID_W-1:0] flush_asid,
   output logic              fence_ack
);
   walk_arb_state_t   state_reg, state_next;
   logic              req_reg, req_next;
   logic [VA_W-1:0]   vaddr_reg, vaddr_next;
   logic              is_store_reg, is_store_next;
   logic              is_fetch_reg, is_fetch_next;
   logic              ifill_reg, ifill_next;
   logic              dfill_reg, dfill_next;
   logic [31:0]       pte_reg, pte_next;
   logic              ifault_reg, ifault_next;
   logic              lfault_reg, lfault_next;
   logic              sfault_reg, sfault_next;
   logic              flush_reg, flush_next;
   logic [VA_W-1:0]   fva_reg, fva_next;
   logic [ASID_W-1:0] fasid_reg, fasid_next;

   logic      itlb_ok, dtlb_ok, starve_sat, i_grant, d_grant, cancel;
   walk_src_t grant_src;

   assign itlb_ok   = itlb_miss && !pc_redirect && !intr;
   assign dtlb_ok   = dtlb_miss && !intr;
   // A waiting iTLB miss overtakes the dTLB only once it has been starved long enough.
   assign i_grant   = (state_reg == IDLE) && !fence_req && itlb_ok && (!dtlb_ok || starve_sat);
   assign d_grant   = (state_reg == IDLE) && !fence_req && dtlb_ok && !i_grant;
   assign grant_src = i_grant ? SRC_I : SRC_D;
   assign cancel    = intr || ((state_reg == WALK_I) && pc_redirect);

   walk_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
      .CLK  (CLK),
      .nRST (nRST),
      .inc  (d_grant && itlb_miss),
      .clr  (i_grant || !itlb_miss),
      .sat  (starve_sat)
   );

   always_comb begin
      state_next    = state_reg;
      req_next      = req_reg;
      vaddr_next    = vaddr_reg;
      is_store_next = is_store_reg;
      is_fetch_next = is_fetch_reg;
      pte_next      = pte_reg;
      fva_next      = fva_reg;
      fasid_next    = fasid_reg;
      ifill_next    = 1'b0;
      dfill_next    = 1'b0;
      ifault_next   = 1'b0;
      lfault_next   = 1'b0;
      sfault_next   = 1'b0;
      flush_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (fence_req) begin
               state_next = FLUSH;
               flush_next = 1'b1;
               fva_next   = fence_va;
               fasid_next = fence_asid;
            end else if (i_grant || d_grant) begin
               state_next    = (grant_src == SRC_I) ? WALK_I : WALK_D;
               req_next      = 1'b1;
               vaddr_next    = (grant_src == SRC_I) ? itlb_vaddr : dtlb_vaddr;
               is_store_next = (grant_src == SRC_D) && ex_mem_wen;
               is_fetch_next = (grant_src == SRC_I);
            end
         end
         WALK_I, WALK_D: begin
            if (ptw.ptw_done) begin
               req_next   = 1'b0;
               state_next = IDLE;
               if (cancel) begin
                  state_next = IDLE;
               end else if (fence_req) begin
                  // Result is stale once a fence is pending; flush instead of filling.
                  state_next = FLUSH;
                  flush_next = 1'b1;
                  fva_next   = fence_va;
                  fasid_next = fence_asid;
               end else if (!ptw.ptw_fault) begin
                  pte_next   = ptw.ptw_pte;
                  ifill_next = (state_reg == WALK_I);
                  dfill_next = (state_reg == WALK_D);
               end else if (state_reg == WALK_I) begin
                  ifault_next = 1'b1;
               end else begin
                  sfault_next = is_store_reg;
                  lfault_next = !is_store_reg;
               end
            end else if (cancel) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (ptw.ptw_done) begin
               req_next   = 1'b0;
               state_next = IDLE;
            end
         end
         FLUSH:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg    <= IDLE;
         req_reg      <= 1'b0;
         vaddr_reg    <= '0;
         is_store_reg <= 1'b0;
         is_fetch_reg <= 1'b0;
         ifill_reg    <= 1'b0;
         dfill_reg    <= 1'b0;
         pte_reg      <= '0;
         ifault_reg   <= 1'b0;
         lfault_reg   <= 1'b0;
         sfault_reg   <= 1'b0;
         flush_reg    <= 1'b0;
         fva_reg      <= '0;
         fasid_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         req_reg      <= req_next;
         vaddr_reg    <= vaddr_next;
         is_store_reg <= is_store_next;
         is_fetch_reg <= is_fetch_next;
         ifill_reg    <= ifill_next;
         dfill_reg    <= dfill_next;
         pte_reg      <= pte_next;
         ifault_reg   <= ifault_next;
         lfault_reg   <= lfault_next;
         sfault_reg   <= sfault_next;
         flush_reg    <= flush_next;
         fva_reg      <= fva_next;
         fasid_reg    <= fasid_next;
      end
   end

   assign ptw.ptw_req          = req_reg;
   assign ptw.ptw_vaddr        = vaddr_reg;
   assign ptw.ptw_is_store     = is_store_reg;
   assign ptw.ptw_is_fetch     = is_fetch_reg;
   assign itlb_fill             = ifill_reg;
   assign dtlb_fill             = dfill_reg;
   assign fill_pte              = pte_reg;
   assign fetch_fault_insn_page = ifault_reg;
   assign mem_fault_load_page   = lfault_reg;
   assign mem_fault_store_page  = sfault_reg;
   assign tlb_flush             = flush_reg;
   assign fence_ack             = flush_reg;
   assign flush_va              = fva_reg;
   assign flush_asid            = fasid_reg;

   // The walker only answers requests it was given; a done with no walk outstanding is a bug.
   a_done_in_walk: assert property (@(posedge CLK) disable iff (!nRST)
      ptw.ptw_done |-> (state_reg != IDLE && state_reg != FLUSH));
   a_dmiss_is_access: assert property (@(posedge CLK) disable iff (!nRST)
      dtlb_miss |-> (ex_mem_ren || ex_mem_wen));
endmodule
